// File: rtl/adaptive_filter_feeder.sv
// Front-end feeder for the adaptive integrator/differentiator filter.
// Buffers the input sample stream and sequences mode changes by flushing
// the filter with zero samples before applying the new ctrl value.
module adaptive_filter_feeder #(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FLUSH_LEN  = 12
) (
    input  logic                               clk,
    input  logic                               srst,
    input  logic [DATA_W-1:0]                  in_tdata,
    input  logic                               in_tvalid,
    output logic                               in_tready,
    input  logic                               mode_req,
    input  logic                               mode_req_valid,
    output logic [DATA_W-1:0]                  m_tdata,
    output logic                               m_tvalid,
    output logic                               m_flush,
    output logic                               ctrl,
    output logic                               mode_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FLUSH_LEN + 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              push;
    logic              pop;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              pending;
    logic              pend_eff;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt;
    logic              flush_nxt;
    logic              ctrl_nxt;
    logic              busy_nxt;

    assign push     = in_tvalid & in_tready;
    assign pend_eff = mode_req_valid ? mode_req : pending;

    // Next occupancy; push and pop in the same cycle leave the level unchanged
    always_comb begin
        level_nxt = fifo_level;
        case ({push, pop})
            2'b10:   level_nxt = fifo_level + LVL_W'(1);
            2'b01:   level_nxt = fifo_level - LVL_W'(1);
            default: level_nxt = fifo_level;
        endcase
    end

    // Sample storage; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_tdata;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (srst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            in_tready  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            fifo_level <= level_nxt;
            in_tready  <= (level_nxt != LVL_W'(FIFO_DEPTH));
        end
    end

    // Mode sequencer: next state, flush counter and next output values
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = m_tdata;
        valid_nxt = 1'b0;
        flush_nxt = 1'b0;
        ctrl_nxt  = ctrl;
        busy_nxt  = (state != ST_RUN);
        pop       = 1'b0;
        case (state)
            ST_RUN: begin
                if (fifo_level != '0) begin
                    pop       = 1'b1;
                    data_nxt  = mem[rptr];
                    valid_nxt = 1'b1;
                end
                if (pend_eff != ctrl) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = CNT_W'(FLUSH_LEN - 1);
                end
            end
            ST_FLUSH: begin
                // ctrl held low so the filter's feedback register drains too
                data_nxt  = '0;
                valid_nxt = 1'b1;
                flush_nxt = 1'b1;
                ctrl_nxt  = 1'b0;
                if (cnt == '0) begin
                    state_nxt = ST_SWITCH;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                ctrl_nxt = pending;
                // A request landing on this edge supersedes the value being applied
                if (pend_eff != pending) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = CNT_W'(FLUSH_LEN - 1);
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // State, pending request and registered outputs
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            pending   <= 1'b0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_flush   <= 1'b0;
            ctrl      <= 1'b0;
            mode_busy <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pending   <= pend_eff;
            m_tdata   <= data_nxt;
            m_tvalid  <= valid_nxt;
            m_flush   <= flush_nxt;
            ctrl      <= ctrl_nxt;
            mode_busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_adaptive_filter_feeder.sv
// Bench for adaptive_filter_feeder: directed and random stimulus checked
// every cycle against a transaction-level model of the feeder.
module tb_adaptive_filter_feeder;

    localparam int unsigned DW    = 14;
    localparam int unsigned DEPTH = 16;
    localparam int          FL    = 12;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic [DW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic          mode_req = 1'b0;
    logic          mode_req_valid = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_flush;
    logic          ctrl;
    logic          mode_busy;
    logic [4:0]    fifo_level;

    adaptive_filter_feeder #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FLUSH_LEN(FL)
    ) dut (
        .clk(clk), .srst(srst),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_flush(m_flush),
        .ctrl(ctrl), .mode_busy(mode_busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: queue of accepted words, applied mode, requested mode and
    // position inside a transition (0 = streaming, 1..FL = zero sample
    // number, FL+1 = the edge that applies the new mode).
    logic [DW-1:0] q [$];
    logic          mode_now = 1'b0;
    logic          mode_want = 1'b0;
    int            tr = 0;
    logic [DW-1:0] e_data = '0;
    logic          e_valid = 1'b0;
    logic          e_flush = 1'b0;
    logic          e_ctrl = 1'b0;
    logic          e_busy = 1'b0;
    logic          e_tready = 1'b0;
    logic          saw_full = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare
    task automatic cyc(input logic rst, input logic tv, input logic [DW-1:0] d,
                       input logic mv, input logic mr);
        logic accepted;
        logic want;
        srst = rst; in_tvalid = tv; in_tdata = d; mode_req_valid = mv; mode_req = mr;
        @(posedge clk);
        if (rst) begin
            q.delete();
            tr = 0; mode_now = 1'b0; mode_want = 1'b0;
            e_data = '0; e_valid = 1'b0; e_flush = 1'b0; e_ctrl = 1'b0;
            e_busy = 1'b0; e_tready = 1'b0;
        end else begin
            accepted = tv && e_tready;
            want = mv ? mr : mode_want;
            e_busy = (tr != 0);
            if (tr == 0) begin
                e_flush = 1'b0;
                e_ctrl = mode_now;
                if (q.size() > 0) begin
                    e_data = q.pop_front();
                    e_valid = 1'b1;
                end else begin
                    e_valid = 1'b0;
                end
                if (want != mode_now) tr = 1;
            end else if (tr <= FL) begin
                e_data = '0; e_valid = 1'b1; e_flush = 1'b1; e_ctrl = 1'b0;
                tr = tr + 1;
            end else begin
                e_valid = 1'b0; e_flush = 1'b0;
                mode_now = mode_want;
                e_ctrl = mode_want;
                tr = (want != mode_want) ? 1 : 0;
            end
            mode_want = want;
            if (accepted) q.push_back(d);
            e_tready = (q.size() != DEPTH);
        end
        #1;
        chk("m_tdata",    32'(m_tdata),    32'(e_data));
        chk("m_tvalid",   32'(m_tvalid),   32'(e_valid));
        chk("m_flush",    32'(m_flush),    32'(e_flush));
        chk("ctrl",       32'(ctrl),       32'(e_ctrl));
        chk("mode_busy",  32'(mode_busy),  32'(e_busy));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("in_tready",  32'(in_tready),  32'(e_tready));
        if (fifo_level == 5'd16 && !in_tready) saw_full = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] w;
        logic          retrig;
        int            n_rst;

        // Reset and the idle cycle after it
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 14'h0055, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 14'h0077, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Three back-to-back words stream through with one cycle of latency
        cyc(1'b0, 1'b1, 14'h0040, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 14'h3FC0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 14'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Switch to integrator under continuous input; re-request on the
        // switch edge so a second flush follows and the FIFO fills up
        retrig = 1'b0;
        for (int i = 0; i < 70; i++) begin
            w = DW'($urandom);
            if (i == 0) begin
                cyc(1'b0, 1'b1, w, 1'b1, 1'b1);
            end else if (tr == FL + 1 && !retrig) begin
                retrig = 1'b1;
                cyc(1'b0, 1'b1, w, 1'b1, ~mode_want);
            end else begin
                cyc(1'b0, 1'b1, w, 1'b0, 1'b0);
            end
        end
        chk("fifo_full_seen", 32'(saw_full), 32'd1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Reach integrator mode, then request 0 and 1 inside the flush
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("ctrl_after_switch", 32'(ctrl), 32'd1);
        cyc(1'b0, 1'b1, 14'h0101, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) begin
            w = DW'($urandom);
            if (tr == 3)      cyc(1'b0, 1'b1, w, 1'b1, 1'b1);
            else if (tr == 6) cyc(1'b0, 1'b1, w, 1'b1, 1'b0);
            else if (tr == 8) cyc(1'b0, 1'b1, w, 1'b1, 1'b1);
            else              cyc(1'b0, 1'b1, w, 1'b0, 1'b0);
        end
        chk("ctrl_kept", 32'(ctrl), 32'd1);
        // Request matching the current mode is dropped
        cyc(1'b0, 1'b1, 14'h0202, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b0);
        chk("no_flush_same_mode", 32'(m_flush), 32'd0);

        // Reset in the middle of a flush with words queued
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        while (tr != 5) cyc(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_mid_flush_level", 32'(fifo_level), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Random traffic, mode requests and occasional resets
        n_rst = 0;
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 299) == 0);
            if (r) n_rst++;
            cyc(r, ($urandom_range(0, 3) != 0), DW'($urandom),
                ($urandom_range(0, 19) == 0), 1'($urandom));
        end
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adaptive_filter_feeder.md
Name: adaptive_filter_feeder

Overview:
Upstream stage of the adaptive integrator/differentiator filter. It buffers a ready/valid Q8.6 sample stream in a small FIFO and drives the filter's s_tdata/s_tvalid/ctrl inputs. It handles mode-change requests safely: it stalls real data, flushes the filter's delay line and integrator feedback loop with zero samples in differentiator mode, then applies the new ctrl value. The filter never sees ctrl toggle with stale history.

Parameters:
DATA_W, 14, sample width (signed Q8.6, bits [7:-6] packed as [13:0])
FIFO_DEPTH, 16, input FIFO entries (power of two, ≥2)
FLUSH_LEN, 12, zero samples emitted per flush; must be ≥ filter delay-line depth + 2 (feedback loop stages)

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
in_tdata  in  DATA_W  input sample
in_tvalid  in  1  input sample valid
in_tready  out  1  FIFO can accept; transfer when in_tvalid & in_tready
mode_req  in  1  requested mode: 1 integrator, 0 differentiator
mode_req_valid  in  1  single-cycle strobe qualifying mode_req
m_tdata  out  DATA_W  sample to filter s_tdata
m_tvalid  out  1  to filter s_tvalid; no backpressure
m_flush  out  1  high with m_tvalid on flush (zero) samples; lets downstream discard filter output
ctrl  out  1  filter mode select
mode_busy  out  1  flush/switch in progress or a request pending
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset: all outputs registered. During srst and the cycle after: m_tdata=0, m_tvalid=0, m_flush=0, ctrl=0, mode_busy=0, fifo_level=0, in_tready=0. From the first post-reset edge: in_tready=1, state RUN, FIFO empty, pending request cleared. Reset mid-flush aborts the flush; ctrl returns to 0.
- FIFO: in_tready = !full, registered from occupancy. A push is blocked when full, even if a pop occurs the same cycle. Simultaneous push and pop keep the level unchanged. Read/write pointers wrap modulo FIFO_DEPTH. Input is accepted in every state.
- State machine RUN / FLUSH / SWITCH:
  - RUN: on each edge, if FIFO non-empty, pop one word: m_tdata=word, m_tvalid=1, m_flush=0. Otherwise m_tvalid=0 and m_tdata holds its last value. Minimum latency is 1 cycle: a word accepted at edge k into an empty FIFO appears at edge k+1. ctrl holds.
  - Mode request: mode_req_valid sampled at edge k latches pending=mode_req (latest request wins).
    - In RUN, if pending==ctrl, the request is dropped with no flush.
    - Otherwise the RUN action still applies at edge k, and the FSM enters FLUSH.
  - FLUSH: edges k+1..k+FLUSH_LEN present m_tdata=0, m_tvalid=1, m_flush=1, ctrl=0. ctrl is forced to 0 so the filter's feedback register clears. No FIFO pops. A down-counter runs from FLUSH_LEN-1 to 0.
  - SWITCH: edge k+FLUSH_LEN+1 presents ctrl=pending, m_tvalid=0, m_flush=0. At the next edge:
    - if pending≠ctrl (a newer request arrived), return to FLUSH;
    - otherwise go to RUN, with the first data pop at edge k+FLUSH_LEN+2.
  - Requests arriving in FLUSH or SWITCH only update pending; the flush in progress is not restarted.
- mode_busy=1 from edge k+1 until the cycle the FSM re-enters RUN with pending==ctrl.
- Data path: no arithmetic. Words pass through unmodified, bit-exact, in FIFO order. A full FIFO during a flush back-pressures the source via in_tready; data is never dropped.

Test Plan:
1. Reset, then push 0x0040, 0x3FC0, 0x1234 on consecutive cycles with mode idle -> m_tvalid high on edges 1,2,3 after the first push, with the same values; m_flush=0; ctrl=0; fifo_level ≤1.
2. ctrl=0, request mode_req=1 at edge k while 5 words are queued -> the word popped at edge k is output; 12 zero samples with m_flush=1 and ctrl=0 follow; at edge k+13 ctrl=1 and m_tvalid=0; the remaining 4 words resume at edge k+14; mode_busy deasserts at edge k+14.
3. Continuous in_tvalid during a flush -> fifo_level reaches 16 and in_tready drops to 0 at the full cycle; no words are lost; the output order after resume matches the input order exactly.
4. ctrl=1, request 0 then request 1 inside FLUSH -> SWITCH keeps ctrl=1 (pending equals current); return to RUN with no second flush. Separately: request 1 in RUN while ctrl=1 -> ignored, no m_flush pulses.
5. Request during SWITCH that differs from the new ctrl -> a second 12-cycle flush begins immediately after SWITCH; ctrl ends at the latest requested value.
6. Assert srst on the 5th flush cycle with 3 words queued -> the next edge has m_tvalid=0, ctrl=0, fifo_level=0, mode_busy=0; queued words are discarded.
